// File: rtl/kmbox_spi_master_if.sv
// Frame handshake and SPI pin bundle for the KMBox SPI master stage.
// The master modport is the SPI-master (design) side; slave is the upstream engine plus SPI slave side.
`timescale 1ns/1ps
interface kmbox_spi_master_if;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        drop_err;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  tx_data, tx_valid, spi_miso,
    output tx_ready, rx_data, rx_valid, drop_err, spi_sck, spi_cs_n, spi_mosi
  );

  modport slave (
    output tx_data, tx_valid, spi_miso,
    input  tx_ready, rx_data, rx_valid, drop_err, spi_sck, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/kmbox_spi_master.sv
// 64-bit full-duplex SPI mode-0 master toward the KMBox RP2350, MSB first,
// fed through a one-entry skid register that absorbs one extra valid pulse.
`timescale 1ns/1ps
module kmbox_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP_CLKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  kmbox_spi_master_if.master bus
);

  localparam int unsigned    CW  = 16;
  localparam logic [CW-1:0]  ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [63:0]   shift_q, shift_d;
  logic [63:0]   skid_q, skid_d;
  logic          skid_full_q, skid_full_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic [63:0]   rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          drop_q, drop_d;
  logic          tx_ready_q, tx_ready_d;
  logic          miso_s1_q, miso_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      drop_q      <= drop_d;
      tx_ready_q  <= tx_ready_d;
      miso_s1_q   <= bus.spi_miso;
      miso_s2_q   <= miso_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    drop_d      = drop_q;

    unique case (state_q)
      IDLE: begin
        if (skid_full_q) begin
          shift_d     = skid_q;
          skid_full_d = 1'b0;
          cs_n_d      = 1'b0;
          mosi_d      = skid_q[63];
          cnt_d       = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      // Every bit, including bit 63, spends a full high and a full low phase here,
      // so CS_n stays low for CS_SETUP + 128*CLK_DIV + CS_HOLD cycles.
      SHIFT: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d   = 1'b0;
            shift_d = {shift_q[62:0], miso_s2_q};
            if (bit_q != 6'd63) mosi_d = shift_q[62];
          end else if (bit_q == 6'd63) begin
            state_d = HOLD;
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CLKS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture landing in the same cycle the FSM drains the skid wins the slot.
    if (bus.tx_valid) begin
      if (skid_full_d) begin
        drop_d = 1'b1;
      end else begin
        skid_d      = bus.tx_data;
        skid_full_d = 1'b1;
      end
    end

    tx_ready_d = (state_d == IDLE) && !skid_full_d;
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.drop_err = drop_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_mosi = mosi_q;

endmodule

// File: tb/tb_kmbox_spi_master.sv
// Scoreboard bench for kmbox_spi_master: a frame monitor checks bus timing and
// pops expected MOSI/MISO words; scenario tasks check control behaviour inline.
`timescale 1ns/1ps
module tb_kmbox_spi_master;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  kmbox_spi_master_if bus ();
  kmbox_spi_master_if bus3 ();

  kmbox_spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .GAP_CLKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  kmbox_spi_master #(.CLK_DIV(3), .CS_SETUP(2), .CS_HOLD(2), .GAP_CLKS(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  // SPI slave side: loopback or a fixed pattern updated on SCK fall
  logic        use_pat = 1'b0;
  logic [63:0] pattern = '0;
  logic [63:0] pat_sh  = '0;
  assign bus.spi_miso  = use_pat ? pat_sh[63] : bus.spi_mosi;
  assign bus3.spi_miso = bus3.spi_mosi;
  always @(negedge bus.spi_cs_n) pat_sh = pattern;
  always @(negedge bus.spi_sck)  pat_sh = {pat_sh[62:0], 1'b0};

  // Scoreboard queues and frame monitor state
  logic [63:0] exp_rx[$];
  logic [63:0] exp_tx[$];
  logic [63:0] e_word, mosi_cap;
  logic cs_prev = 1'b1, sck_prev = 1'b0, rxv_prev = 1'b0;
  int cs_cnt = 0, rises = 0, hi_cnt = 0, last_gap = 0, stray = 0;
  int rx_pulses = 0, frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_prev = 1'b1; sck_prev = 1'b0; rxv_prev = 1'b0;
      cs_cnt = 0; rises = 0; hi_cnt = 0; stray = 0;
    end else begin
      if (bus.spi_cs_n && cs_prev && (bus.spi_sck !== sck_prev)) stray++;
      if (!bus.spi_cs_n && cs_prev) begin
        frames++; cs_cnt = 0; rises = 0; last_gap = hi_cnt; hi_cnt = 0;
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL sck_edges_cs_high got %0d want 0", stray); end
      end
      if (!bus.spi_cs_n) begin
        cs_cnt++;
        if (bus.spi_sck && !sck_prev) begin
          rises++;
          mosi_cap = {mosi_cap[62:0], bus.spi_mosi};
          if (rises == 1) begin
            checks++;
            if (cs_cnt !== 3) begin errors++; $display("FAIL cs_to_sck got %0d want 3", cs_cnt); end
          end
        end
      end else begin
        hi_cnt++;
      end
      if (bus.spi_cs_n && !cs_prev) begin
        checks += 3;
        if (cs_cnt !== 516) begin errors++; $display("FAIL cs_low_cycles got %0d want 516", cs_cnt); end
        if (rises !== 64) begin errors++; $display("FAIL sck_rises got %0d want 64", rises); end
        if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL rxv_at_cs_rise got %b want 1", bus.rx_valid); end
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL mosi_unexpected_frame got %h want none", mosi_cap);
        end else begin
          e_word = exp_tx.pop_front();
          if (mosi_cap !== e_word) begin errors++; $display("FAIL mosi_bits got %h want %h", mosi_cap, e_word); end
        end
      end
      if (bus.rx_valid) begin
        rx_pulses++;
        checks += 2;
        if (rxv_prev) begin errors++; $display("FAIL rxv_consecutive got 1 want 0"); end
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL rx_unexpected got %h want none", bus.rx_data);
        end else begin
          e_word = exp_rx.pop_front();
          if (bus.rx_data !== e_word) begin errors++; $display("FAIL rx_data got %h want %h", bus.rx_data, e_word); end
        end
      end
      cs_prev = bus.spi_cs_n; sck_prev = bus.spi_sck; rxv_prev = bus.rx_valid;
    end
  end

  task automatic send(input logic [63:0] d, input logic [63:0] rx, input bit push);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    if (push) begin exp_tx.push_back(d); exp_rx.push_back(rx); end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_rx.size() == 0 && bus.tx_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tx_valid = 1'b0;  bus.tx_data = '0;
    bus3.tx_valid = 1'b0; bus3.tx_data = '0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b want 1", bus.spi_cs_n); end
    if (bus.spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", bus.spi_sck); end
    if (bus.spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", bus.spi_mosi); end
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b want 1", bus.tx_ready); end
    if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", bus.rx_valid); end
    if (bus.rx_data !== 64'h0) begin errors++; $display("FAIL rst_rx_data got %h want 0", bus.rx_data); end
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL rst_drop_err got %b want 0", bus.drop_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL idle_tx_ready got %b want 1", bus.tx_ready); end
  endtask

  task automatic test_single();
    bit ok;
    int p0;
    use_pat = 1'b0;
    p0 = rx_pulses;
    send(64'hFE00_0000_0000_0000, 64'hFE00_0000_0000_0000, 1'b1);
    checks += 2;
    if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL single_tx_ready_busy got %b want 0", bus.tx_ready); end
    if (bus.spi_cs_n !== 1'b1) begin errors++; $display("FAIL single_cs_early got %b want 1", bus.spi_cs_n); end
    @(negedge clk);
    checks++;
    if (bus.spi_cs_n !== 1'b0) begin errors++; $display("FAIL single_cs_fall got %b want 0", bus.spi_cs_n); end
    wait_done(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL single_timeout got 0 want 1"); end
    if (rx_pulses - p0 !== 1) begin errors++; $display("FAIL single_rx_pulses got %0d want 1", rx_pulses - p0); end
  endtask

  task automatic test_pattern();
    bit ok;
    use_pat = 1'b1;
    pattern = 64'hA55A_0123_4567_89AB;
    send(64'h0102_0304_0506_0708, 64'hA55A_0123_4567_89AB, 1'b1);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pattern_timeout got 0 want 1"); end
    use_pat = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p0;
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    p0 = rx_pulses;
    send(a, a, 1'b1);
    send(b, b, 1'b1);
    wait_done(ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got 0 want 1"); end
    if (rx_pulses - p0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d want 2", rx_pulses - p0); end
    if (last_gap !== 5) begin errors++; $display("FAIL b2b_cs_high_gap got %0d want 5", last_gap); end
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL b2b_drop_err got %b want 0", bus.drop_err); end
  endtask

  task automatic test_overflow();
    bit ok;
    int f0;
    logic [63:0] a, b;
    a = 64'h1111_2222_3333_4444;
    b = 64'h5555_6666_7777_8888;
    f0 = frames;
    send(a, a, 1'b1);
    send(b, b, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL ovf_drop_early got %b want 0", bus.drop_err); end
    send(64'hDEAD_BEEF_DEAD_BEEF, '0, 1'b0);
    checks++;
    if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL ovf_drop_err got %b want 1", bus.drop_err); end
    wait_done(ok);
    repeat (20) @(negedge clk);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL ovf_timeout got 0 want 1"); end
    if (frames - f0 !== 2) begin errors++; $display("FAIL ovf_frames got %0d want 2", frames - f0); end
    if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL ovf_drop_sticky got %b want 1", bus.drop_err); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit hit;
    int p0;
    p0 = rx_pulses;
    hit = 1'b0;
    send(64'hCAFE_F00D_1234_5678, '0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rises >= 31) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_bit30 got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.spi_cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n got %b want 1", bus.spi_cs_n); end
    if (bus.spi_sck !== 1'b0) begin errors++; $display("FAIL mid_sck got %b want 0", bus.spi_sck); end
    if (bus.spi_mosi !== 1'b0) begin errors++; $display("FAIL mid_mosi got %b want 0", bus.spi_mosi); end
    if (bus.drop_err !== 1'b0) begin errors++; $display("FAIL mid_drop_clear got %b want 0", bus.drop_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks += 2;
    if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_tx_ready got %b want 1", bus.tx_ready); end
    if (rx_pulses !== p0) begin errors++; $display("FAIL mid_no_rx got %0d want %0d", rx_pulses, p0); end
    send(64'h0F1E_2D3C_4B5A_6978, 64'h0F1E_2D3C_4B5A_6978, 1'b1);
    wait_done(ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_next_timeout got 0 want 1"); end
    if (rx_pulses - p0 !== 1) begin errors++; $display("FAIL mid_next_rx got %0d want 1", rx_pulses - p0); end
  endtask

  task automatic test_clkdiv3();
    logic [63:0] q3[$];
    logic [63:0] d, e;
    logic sp;
    int low, nr, last_r, bad_per, got;
    d = 64'h8BAD_F00D_7E57_C0DE;
    q3.push_back(d);
    bus3.tx_data = d;
    bus3.tx_valid = 1'b1;
    @(negedge clk);
    bus3.tx_valid = 1'b0;
    sp = 1'b0; low = 0; nr = 0; last_r = 0; bad_per = 0; got = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!bus3.spi_cs_n) low++;
      if (bus3.spi_sck && !sp) begin
        if (nr > 0 && (i - last_r) != 6) bad_per++;
        nr++; last_r = i;
      end
      sp = bus3.spi_sck;
      if (bus3.rx_valid) begin
        got++;
        checks++;
        if (q3.size() == 0) begin
          errors++; $display("FAIL div3_rx_unexpected got %h want none", bus3.rx_data);
        end else begin
          e = q3.pop_front();
          if (bus3.rx_data !== e) begin errors++; $display("FAIL div3_rx_data got %h want %h", bus3.rx_data, e); end
        end
        break;
      end
    end
    checks += 4;
    if (got !== 1) begin errors++; $display("FAIL div3_rx_count got %0d want 1", got); end
    if (nr !== 64) begin errors++; $display("FAIL div3_sck_rises got %0d want 64", nr); end
    if (bad_per !== 0) begin errors++; $display("FAIL div3_sck_period bad=%0d want 0", bad_per); end
    if (low !== 388) begin errors++; $display("FAIL div3_cs_low got %0d want 388", low); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_pattern();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_clkdiv3();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_rx.size() != 0 || exp_tx.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d/%0d want 0/0", exp_rx.size(), exp_tx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
